cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 exception controller for the 5-stage MIPS pipeline. It sits beside the M stage and consumes the exception tags (`EXcode`, `delay`) that travel down the pipeline registers, along with the M-stage PC and the external hardware interrupt lines. It raises the global flush request `req`, which makes every pipeline register clear and steer PC to 0x0000_4180. It also holds SR, Cause, EPC and PRId for `mfc0`/`mtc0`/`eret`.

## Interface
- `PRID_VAL`, default 32'h2021_0B0A: read-only value of PRId (reg 15).
- `HANDLER_PC`, default 32'h0000_4180: exception entry address; informational here, consumed by the pipeline registers.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `we` in 1: `mtc0` commit in M stage.
- `addr` in 5: CP0 register number for read and write.
- `din` in 32: `mtc0` write data (rt value).
- `pc_in` in 32: PC of the instruction currently in M.
- `delay_in` in 1: M instruction is in a branch delay slot.
- `EXcode_in` in 5: M-stage exception code; 0 = none.
- `eret` in 1: `eret` in M.
- `hw_int` in 6: external interrupt lines, level-sensitive.
- `req` out 1: flush / enter-handler request (combinational).
- `dout` out 32: `mfc0` read data (combinational on `addr`).
- `epc_out` out 32: current EPC, for `eret` redirect.

## Operation
- **SR (12):** IM[15:10], EXL[1], IE[0]. All other bits read 0.
- **Cause (13):** BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
- **EPC (14):** 32-bit register.
- **PRId (15):** constant `PRID_VAL`.
- Any other `addr` reads 0.
- `int_req = IE & ~EXL & |(hw_int & IM)`.
- `exc_req = ~EXL & (EXcode_in != 0)`.
- `req = int_req | exc_req`, forced 0 while `reset` is low.
- **Priority:** interrupt over exception over `eret` over `mtc0`.
- **On a cycle with `req`=1, at the next edge:**
  - EXL <= 1.
  - BD <= `delay_in`.
  - ExcCode <= 0 if `int_req`, else `EXcode_in`.
  - EPC <= `delay_in` ? `{pc_in[31:2],2'b00} - 4` : `{pc_in[31:2],2'b00}`.
  - Any `we`/`eret` in the same cycle is discarded.
- **`eret` with `req`=0:** EXL <= 0. All other fields are unchanged.
- **`we` with `req`=0 and `eret`=0:**
  - addr 12: SR <= {IM, EXL, IE} taken from `din`.
  - addr 14: EPC <= `din`.
  - addr 13 and 15: ignored; Cause and PRId are not software-writable.
- **IP tracking:** IP[15:10] <= `hw_int` every edge, independent of every other event.
- **Masking:** while EXL=1, neither new interrupts nor new exceptions raise `req`. Cause and EPC are frozen except for IP.
- **EPC arithmetic:** 32-bit unsigned, wraps modulo 2^32. Example: `pc_in`=0 with `delay_in`=1 gives EPC=32'hFFFF_FFFC.

## Timing
- **Reset values:** SR=0, Cause=0, EPC=0, `req`=0, `epc_out`=0. `dout` reflects reset register contents: 0, or `PRID_VAL` at addr 15.
- **Reset is asynchronous:** asserting it mid-operation clears state within the same cycle. The first update after release occurs at the first rising edge with `reset` high.
- **`req` latency:** 0 cycles, combinational in the M cycle. State updates land at the end of that cycle.
- **`mfc0`:** read of a register written by `mtc0` in the same cycle returns the old value. The new value is visible from the next cycle; no internal bypass.
- **`epc_out`:** registered EPC. Updated EPC is visible 1 cycle after the write/exception edge.
- **`hw_int`:** a pulse narrower than one cycle between edges is not guaranteed to be seen. IP samples it once per edge.

## Test plan
- **Reset:** drive `reset`=0 mid-cycle with SR=32'h0000_FC01 loaded -> SR, Cause, EPC read 0 immediately; `req`=0; addr 15 reads `PRID_VAL`.
- **Exception:** `EXcode_in`=5'd4, `pc_in`=32'h0000_3010, `delay_in`=0 -> `req`=1 same cycle. Next cycle: EPC=32'h0000_3010, Cause ExcCode=4, BD=0, EXL=1.
- **Delay-slot exception:** `EXcode_in`=5'd10, `pc_in`=32'h0000_3024, `delay_in`=1 -> EPC=32'h0000_3020, Cause[31]=1.
- **Interrupt:**
  - `mtc0` SR=32'h0000_0401, then `hw_int`=6'b000001 -> `req`=1; ExcCode=0; IP[10]=1.
  - With SR IM=0 -> `req` stays 0, but IP[10] still reads 1.
- **Priority and masking:**
  - Interrupt and `EXcode_in`=5'd12 together -> ExcCode=0.
  - While EXL=1, `EXcode_in`=5'd4 -> `req`=0 and EPC unchanged.
  - `eret` -> EXL=0 next cycle.
- **Collisions:**
  - `we` to EPC with `din`=32'h1234_5678 in the same cycle as an exception at `pc_in`=32'h0000_3000 -> EPC=32'h0000_3000.
  - The same `mtc0` without an exception -> `epc_out`=32'h1234_5678 one cycle later.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 exception controller beside the M stage: SR/Cause/EPC/PRId,
// flush request generation for interrupts and exceptions, eret and mtc0 handling.
module cp0_unit #(
  parameter logic [31:0] PRID_VAL   = 32'h2021_0B0A,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic [31:0] pc_in,
  input  logic        delay_in,
  input  logic [4:0]  EXcode_in,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] dout,
  output logic [31:0] epc_out
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] pc_aligned;
  logic [31:0] epc_next;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_req    = ie & ~exl & (|(hw_int & im));
  assign exc_req    = ~exl & (EXcode_in != 5'd0);
  assign req        = reset & (int_req | exc_req);

  // A faulting delay-slot instruction restarts at its branch, one word back.
  assign pc_aligned = {pc_in[31:2], 2'b00};
  assign epc_next   = delay_in ? (pc_aligned - 32'd4) : pc_aligned;

  assign sr_val     = {16'h0000, im, 8'h00, exl, ie};
  assign cause_val  = {bd, 15'h0000, ip, 3'b000, exc_code, 2'b00};
  assign epc_out    = epc;

  always_comb begin
    dout = 32'h0000_0000;
    case (addr)
      5'd12:   dout = sr_val;
      5'd13:   dout = cause_val;
      5'd14:   dout = epc;
      5'd15:   dout = PRID_VAL;
      default: dout = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'h0000_0000;
    end else begin
      ip <= hw_int;
      if (int_req | exc_req) begin
        exl      <= 1'b1;
        bd       <= delay_in;
        exc_code <= int_req ? 5'd0 : EXcode_in;
        epc      <= epc_next;
      end else if (eret) begin
        exl <= 1'b0;
      end else if (we) begin
        case (addr)
          5'd12: begin
            im  <= din[15:10];
            exl <= din[1];
            ie  <= din[0];
          end
          5'd14:   epc <= din;
          default: ;
        endcase
      end
    end
  end

  // Bits with no storage behind them, and the handler address the pipeline uses.
  logic unused_bits;
  assign unused_bits = ^{pc_in[1:0], din[31:16], din[9:2], HANDLER_PC};

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: a vector table of one-cycle transactions with
// pre-edge checks, plus hand sequences for power-on and mid-cycle reset.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2021_0B0A;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] pc_in;
  logic        delay_in;
  logic [4:0]  EXcode_in;
  logic        eret;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] dout;
  logic [31:0] epc_out;

  int total = 0;
  int bad   = 0;

  cp0_unit dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .pc_in     (pc_in),
    .delay_in  (delay_in),
    .EXcode_in (EXcode_in),
    .eret      (eret),
    .hw_int    (hw_int),
    .req       (req),
    .dout      (dout),
    .epc_out   (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] pc;
    logic        dly;
    logic [4:0]  exc;
    logic        eret;
    logic [5:0]  hw;
    logic        exp_req;
    logic [31:0] exp_dout;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t v(logic w, logic [4:0] a, logic [31:0] d, logic [31:0] p,
                             logic dl, logic [4:0] e, logic er, logic [5:0] h,
                             logic xr, logic [31:0] xd, logic [31:0] xe);
    vec_t r;
    r.we = w; r.addr = a; r.din = d; r.pc = p; r.dly = dl; r.exc = e;
    r.eret = er; r.hw = h; r.exp_req = xr; r.exp_dout = xd; r.exp_epc = xe;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 0; addr = 0; din = 0; pc_in = 0; delay_in = 0;
    EXcode_in = 0; eret = 0; hw_int = 0;
  endtask

  initial begin
    //           we addr din           pc            dly exc    eret hw    req dout          epc
    vecs[0]  = v(0, 15, 32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, PRID,         32'h0);
    vecs[1]  = v(0, 12, 32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, 32'h0,        32'h0);
    vecs[2]  = v(0, 13, 32'h0,        32'h3010,     0, 5'd4,  0, 6'h00, 1, 32'h0,        32'h0);
    vecs[3]  = v(0, 13, 32'h0,        32'h5000,     0, 5'd4,  0, 6'h00, 0, 32'h10,       32'h3010);
    vecs[4]  = v(0, 12, 32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, 32'h2,        32'h3010);
    vecs[5]  = v(0, 14, 32'h0,        32'h0,        0, 5'd0,  1, 6'h00, 0, 32'h3010,     32'h3010);
    vecs[6]  = v(0, 12, 32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, 32'h0,        32'h3010);
    vecs[7]  = v(0, 14, 32'h0,        32'h3024,     1, 5'd10, 0, 6'h00, 1, 32'h3010,     32'h3010);
    vecs[8]  = v(0, 13, 32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, 32'h8000_0028, 32'h3020);
    vecs[9]  = v(0, 0,  32'h0,        32'h0,        0, 5'd0,  1, 6'h00, 0, 32'h0,        32'h3020);
    vecs[10] = v(1, 12, 32'h401,      32'h0,        0, 5'd0,  0, 6'h00, 0, 32'h0,        32'h3020);
    vecs[11] = v(0, 12, 32'h0,        32'h4000,     0, 5'd12, 0, 6'h01, 1, 32'h401,      32'h3020);
    vecs[12] = v(0, 13, 32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, 32'h400,      32'h4000);
    vecs[13] = v(0, 12, 32'h0,        32'h0,        0, 5'd0,  1, 6'h00, 0, 32'h403,      32'h4000);
    vecs[14] = v(1, 12, 32'h1,        32'h0,        0, 5'd0,  0, 6'h00, 0, 32'h401,      32'h4000);
    vecs[15] = v(0, 13, 32'h0,        32'h0,        0, 5'd0,  0, 6'h01, 0, 32'h0,        32'h4000);
    vecs[16] = v(0, 13, 32'h0,        32'h0,        0, 5'd0,  0, 6'h01, 0, 32'h400,      32'h4000);
    vecs[17] = v(1, 14, 32'h1234_5678, 32'h3000,    0, 5'd4,  0, 6'h00, 1, 32'h4000,     32'h4000);
    vecs[18] = v(0, 14, 32'h0,        32'h0,        0, 5'd0,  1, 6'h00, 0, 32'h3000,     32'h3000);
    vecs[19] = v(1, 14, 32'h1234_5678, 32'h0,       0, 5'd0,  0, 6'h00, 0, 32'h3000,     32'h3000);
    vecs[20] = v(0, 14, 32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, 32'h1234_5678, 32'h1234_5678);
    vecs[21] = v(1, 13, 32'hFFFF_FFFF, 32'h0,       0, 5'd0,  0, 6'h00, 0, 32'h10,       32'h1234_5678);
    vecs[22] = v(0, 13, 32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, 32'h10,       32'h1234_5678);
    vecs[23] = v(1, 15, 32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, PRID,         32'h1234_5678);
    vecs[24] = v(0, 15, 32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, PRID,         32'h1234_5678);
    vecs[25] = v(0, 7,  32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, 32'h0,        32'h1234_5678);
    vecs[26] = v(0, 14, 32'h0,        32'h3,        1, 5'd1,  0, 6'h00, 1, 32'h1234_5678, 32'h1234_5678);
    vecs[27] = v(0, 14, 32'h0,        32'h0,        0, 5'd0,  0, 6'h00, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);

    // Power-on reset: values visible before any clock edge.
    idle();
    reset = 1'b0;
    #1;
    chk("por req", {31'h0, req}, 32'h0);
    chk("por epc_out", epc_out, 32'h0);
    for (int a = 12; a <= 15; a++) begin
      addr = 5'(a);
      #1;
      chk($sformatf("por dout[%0d]", a), dout, (a == 15) ? PRID : 32'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      we = vecs[i].we; addr = vecs[i].addr; din = vecs[i].din;
      pc_in = vecs[i].pc; delay_in = vecs[i].dly; EXcode_in = vecs[i].exc;
      eret = vecs[i].eret; hw_int = vecs[i].hw;
      #1;
      chk($sformatf("v%0d req", i), {31'h0, req}, {31'h0, vecs[i].exp_req});
      chk($sformatf("v%0d dout", i), dout, vecs[i].exp_dout);
      chk($sformatf("v%0d epc_out", i), epc_out, vecs[i].exp_epc);
    end

    // Clear EXL, load SR, then pull reset mid-cycle.
    @(negedge clk);
    idle();
    eret = 1;
    @(negedge clk);
    idle();
    we = 1; addr = 12; din = 32'h0000_FC01;
    @(negedge clk);
    idle();
    addr = 12;
    #1;
    chk("sr loaded", dout, 32'h0000_FC01);
    EXcode_in = 5'd4; hw_int = 6'h3F;
    #1;
    chk("pre-reset req", {31'h0, req}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid reset req", {31'h0, req}, 32'h0);
    chk("mid reset sr", dout, 32'h0);
    addr = 13; #1;
    chk("mid reset cause", dout, 32'h0);
    addr = 14; #1;
    chk("mid reset epc", dout, 32'h0);
    chk("mid reset epc_out", epc_out, 32'h0);
    addr = 15; #1;
    chk("mid reset prid", dout, PRID);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle();
    EXcode_in = 5'd4; pc_in = 32'h0000_0100;
    #1;
    chk("post reset req", {31'h0, req}, 32'h1);
    @(posedge clk);
    #1;
    chk("post reset epc", epc_out, 32'h0000_0100);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
